sgmii_pcs_tx_ordered_set: RTL and testbench

- PCS transmit ordered-set generator (IEEE 802.3 Clause 36/37 style). It is the transmit-side counterpart of the auto-negotiation controller.
- Consumes the controller's Xmit mode and TxConfigReg, plus GMII transmit data.
- Emits one 8-bit code group per enabled cycle, with a K flag, to the downstream 8b10b encoder: /C1/ /C2/ config sets, /I1/ /I2/ idles, or /S/ data /T/ /R/ framed packets.

---
 rtl/sgmii_pcs_tx_ordered_set.sv | 181 ++++++++++++++++++
 tb/tb_sgmii_pcs_tx_ordered_set.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_pcs_tx_ordered_set.sv
// PCS transmit ordered-set generator. Turns the auto-negotiation Xmit mode,
// the config word and GMII transmit data into one 8-bit code group (plus K
// flag) per enabled cycle for the downstream 8b10b encoder.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// sIdle     | idle pairs /I1/ /I2/ (IDLE mode, or DATA mode with no packet)
// sSopWait  | TX_EN rose on an odd slot; /S/ goes out on the next even slot
// sConfig   | /C1/ /C2/ sequence; rCfgSlot is the slot of the current output
// sData     | packet active, /S/ already sent
// sEopT     | /T/ just sent, /R/ follows
// sEopR     | /R/ landed on an even slot, extra /R/ restores alignment
module sgmii_pcs_tx_ordered_set #(
    parameter logic [2:0] XMIT_IDLE   = 3'b001,
    parameter logic [2:0] XMIT_CONFIG = 3'b010,
    parameter logic [2:0] XMIT_DATA   = 3'b100
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Cke,
    input  logic [2:0]  i3_Xmit,
    input  logic [15:0] i16_TxConfigReg,
    input  logic        i_TxEn,
    input  logic        i_TxEr,
    input  logic [7:0]  i8_TxD,
    input  logic        i_RunDispNeg,
    output logic [7:0]  o8_TxCodeGroup,
    output logic        o_TxIsK,
    output logic        o_TxEven,
    output logic        o_Transmitting
);

    localparam logic [7:0] cK28_5 = 8'hBC;
    localparam logic [7:0] cD21_5 = 8'hB5;
    localparam logic [7:0] cD2_2  = 8'h42;
    localparam logic [7:0] cD5_6  = 8'hC5;
    localparam logic [7:0] cD16_2 = 8'h50;
    localparam logic [7:0] cSop   = 8'hFB;
    localparam logic [7:0] cEop   = 8'hFD;
    localparam logic [7:0] cCarry = 8'hF7;
    localparam logic [7:0] cErr   = 8'hFE;

    typedef enum logic [2:0] {sIdle, sSopWait, sConfig, sData, sEopT, sEopR} state_t;
    typedef enum logic [1:0] {mIdle, mConfig, mData} mode_t;

    state_t      rState;
    mode_t       rMode;
    logic [2:0]  rCfgSlot;
    logic [15:0] rCfg;
    logic [7:0]  rCode;
    logic        rIsK;
    logic        rEven;
    logic        rTx;

    mode_t       wXmitMode;
    logic        wNextEven;
    logic        wAlign;
    logic [2:0]  wCfgNext;
    logic [7:0]  wIdleOdd;

    // Decode Xmit; anything that is not exactly CONFIG or DATA counts as IDLE.
    always_comb begin
        wXmitMode = mIdle;
        if (i3_Xmit == XMIT_CONFIG)
            wXmitMode = mConfig;
        else if (i3_Xmit == XMIT_DATA)
            wXmitMode = mData;
    end

    // Mode may only change at an even-slot boundary outside a packet, and
    // inside CONFIG only once the full /C2/ has gone out.
    assign wNextEven = ~rEven;
    assign wCfgNext  = rCfgSlot + 3'd1;
    assign wIdleOdd  = i_RunDispNeg ? cD16_2 : cD5_6;
    assign wAlign    = wNextEven &&
                       ((rState == sIdle) || (rState == sSopWait) ||
                        ((rState == sConfig) && (rCfgSlot == 3'd7)));

    // Ordered-set sequencer with registered code group outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rState   <= sIdle;
            rMode    <= mIdle;
            rCfgSlot <= 3'd0;
            rCfg     <= 16'h0000;
            rCode    <= cK28_5;
            rIsK     <= 1'b1;
            rEven    <= 1'b1;
            rTx      <= 1'b0;
        end else if (i_Cke) begin
            rEven <= ~rEven;
            if (wAlign) begin
                rMode <= wXmitMode;
                if (wXmitMode == mConfig) begin
                    rState   <= sConfig;
                    rCfgSlot <= 3'd0;
                    rCfg     <= i16_TxConfigReg;
                    rCode    <= cK28_5;
                    rIsK     <= 1'b1;
                    rTx      <= 1'b0;
                end else if ((wXmitMode == mData) && i_TxEn) begin
                    rState <= sData;
                    rCode  <= cSop;
                    rIsK   <= 1'b1;
                    rTx    <= 1'b1;
                end else begin
                    rState <= sIdle;
                    rCode  <= cK28_5;
                    rIsK   <= 1'b1;
                    rTx    <= 1'b0;
                end
            end else begin
                case (rState)
                    sIdle: begin
                        // Odd slot: second octet of /I1/ or /I2/.
                        rCode <= wIdleOdd;
                        rIsK  <= 1'b0;
                        rTx   <= 1'b0;
                        if ((rMode == mData) && i_TxEn)
                            rState <= sSopWait;
                    end
                    sConfig: begin
                        rCfgSlot <= wCfgNext;
                        rIsK     <= (wCfgNext == 3'd4);
                        rTx      <= 1'b0;
                        case (wCfgNext)
                            3'd1:    rCode <= cD21_5;
                            3'd2:    rCode <= rCfg[7:0];
                            3'd3:    rCode <= rCfg[15:8];
                            3'd4: begin
                                rCode <= cK28_5;
                                rCfg  <= i16_TxConfigReg;
                            end
                            3'd5:    rCode <= cD2_2;
                            3'd6:    rCode <= rCfg[7:0];
                            default: rCode <= rCfg[15:8];
                        endcase
                    end
                    sData: begin
                        rTx <= 1'b1;
                        if ((wXmitMode != mData) || !i_TxEn) begin
                            rState <= sEopT;
                            rCode  <= cEop;
                            rIsK   <= 1'b1;
                        end else if (i_TxEr) begin
                            rCode <= cErr;
                            rIsK  <= 1'b1;
                        end else begin
                            rCode <= i8_TxD;
                            rIsK  <= 1'b0;
                        end
                    end
                    sEopT: begin
                        rCode  <= cCarry;
                        rIsK   <= 1'b1;
                        rTx    <= 1'b0;
                        rState <= wNextEven ? sEopR : sIdle;
                    end
                    sEopR: begin
                        rCode  <= cCarry;
                        rIsK   <= 1'b1;
                        rTx    <= 1'b0;
                        rState <= sIdle;
                    end
                    default: begin
                        rCode  <= cK28_5;
                        rIsK   <= 1'b1;
                        rTx    <= 1'b0;
                        rState <= sIdle;
                    end
                endcase
            end
        end
    end

    assign o8_TxCodeGroup = rCode;
    assign o_TxIsK        = rIsK;
    assign o_TxEven       = rEven;
    assign o_Transmitting = rTx;

endmodule

// File: tb/tb_sgmii_pcs_tx_ordered_set.sv
// Directed bench for the PCS transmit ordered-set generator: a table of
// per-cycle inputs and expected code groups, plus a clock-enable hold sequence.
module tb_sgmii_pcs_tx_ordered_set;

    localparam logic [2:0] XI = 3'b001;
    localparam logic [2:0] XC = 3'b010;
    localparam logic [2:0] XD = 3'b100;

    typedef struct {
        logic        rst;
        logic        cke;
        logic [2:0]  xmit;
        logic [15:0] cfg;
        logic        txEn;
        logic        txEr;
        logic [7:0]  txd;
        logic        rdn;
    } inVec_t;

    typedef struct {
        inVec_t     in;
        logic [7:0] code;
        logic       isK;
        logic       even;
        logic       tx;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cke;
    logic [2:0]  xmit;
    logic [15:0] cfg;
    logic        txEn;
    logic        txEr;
    logic [7:0]  txd;
    logic        rdn;
    logic [7:0]  codeGroup;
    logic        isK;
    logic        even;
    logic        transmitting;

    int     nChecks = 0;
    int     nErrors = 0;
    inVec_t cur;
    vec_t   vecs[$];

    sgmii_pcs_tx_ordered_set #(
        .XMIT_IDLE   (XI),
        .XMIT_CONFIG (XC),
        .XMIT_DATA   (XD)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Cke           (cke),
        .i3_Xmit         (xmit),
        .i16_TxConfigReg (cfg),
        .i_TxEn          (txEn),
        .i_TxEr          (txEr),
        .i8_TxD          (txd),
        .i_RunDispNeg    (rdn),
        .o8_TxCodeGroup  (codeGroup),
        .o_TxIsK         (isK),
        .o_TxEven        (even),
        .o_Transmitting  (transmitting)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    function automatic void addVec(logic [7:0] c, logic k, logic e, logic t);
        vec_t v;
        v.in   = cur;
        v.code = c;
        v.isK  = k;
        v.even = e;
        v.tx   = t;
        vecs.push_back(v);
    endfunction

    task automatic applyIn(inVec_t v);
        rst  = v.rst;
        cke  = v.cke;
        xmit = v.xmit;
        cfg  = v.cfg;
        txEn = v.txEn;
        txEr = v.txEr;
        txd  = v.txd;
        rdn  = v.rdn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(string name, int idx, logic [7:0] act, logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s at step %0d: got %02h, expected %02h", name, idx, act, exp);
        end
    endtask

    task automatic check1(string name, int idx, logic act, logic exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s at step %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(int idx, logic [7:0] c, logic k, logic e, logic t);
        check8("code", idx, codeGroup, c);
        check1("isK", idx, isK, k);
        check1("even", idx, even, e);
        check1("transmitting", idx, transmitting, t);
    endtask

    initial begin
        // Reset held four cycles.
        cur = '{rst: 1'b1, cke: 1'b1, xmit: XI, cfg: 16'h0000, txEn: 1'b0,
                txEr: 1'b0, txd: 8'h00, rdn: 1'b1};
        repeat (4) addVec(8'hBC, 1, 1, 0);

        // IDLE with negative disparity -> /I2/.
        cur.rst = 1'b0;
        addVec(8'h50, 0, 0, 0); addVec(8'hBC, 1, 1, 0);
        addVec(8'h50, 0, 0, 0); addVec(8'hBC, 1, 1, 0);

        // Illegal Xmit with TX_EN high behaves as IDLE; positive disparity -> /I1/.
        cur.xmit = 3'b110; cur.txEn = 1'b1; cur.rdn = 1'b0;
        addVec(8'hC5, 0, 0, 0); addVec(8'hBC, 1, 1, 0);

        // CONFIG, waits for the even boundary, then full /C1/ /C2/ sets.
        cur.xmit = XC; cur.txEn = 1'b0; cur.rdn = 1'b1; cur.cfg = 16'h41A0;
        addVec(8'h50, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'hB5, 0, 0, 0);
        addVec(8'hA0, 0, 1, 0); addVec(8'h41, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'h42, 0, 0, 0);
        addVec(8'hA0, 0, 1, 0); addVec(8'h41, 0, 0, 0);
        // Config word change at B5: current /C1/ keeps old capture, /C2/ picks it up.
        addVec(8'hBC, 1, 1, 0);
        cur.cfg = 16'h01A0;
        addVec(8'hB5, 0, 0, 0); addVec(8'hA0, 0, 1, 0); addVec(8'h41, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'h42, 0, 0, 0);
        addVec(8'hA0, 0, 1, 0); addVec(8'h01, 0, 0, 0);
        // Leaving CONFIG mid-/C1/ still completes /C1/ and /C2/.
        addVec(8'hBC, 1, 1, 0);
        cur.xmit = XD;
        addVec(8'hB5, 0, 0, 0); addVec(8'hA0, 0, 1, 0); addVec(8'h01, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'h42, 0, 0, 0);
        addVec(8'hA0, 0, 1, 0); addVec(8'h01, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0);

        // DATA mode idle, disparity toggling.
        cur.rdn = 1'b0; addVec(8'hC5, 0, 0, 0);
        cur.rdn = 1'b1; addVec(8'hBC, 1, 1, 0); addVec(8'h50, 0, 0, 0);
        cur.rdn = 1'b0; addVec(8'hBC, 1, 1, 0);
        cur.rdn = 1'b1; addVec(8'h50, 0, 0, 0);

        // Even-slot start, six-octet packet, /R/ lands odd.
        cur.txEn = 1'b1;
        cur.txd = 8'h55; addVec(8'hFB, 1, 1, 1);
        cur.txd = 8'h55; addVec(8'h55, 0, 0, 1);
        cur.txd = 8'hD5; addVec(8'hD5, 0, 1, 1);
        cur.txd = 8'h01; addVec(8'h01, 0, 0, 1);
        cur.txd = 8'h02; addVec(8'h02, 0, 1, 1);
        cur.txd = 8'h03; addVec(8'h03, 0, 0, 1);
        cur.txEn = 1'b0;
        addVec(8'hFD, 1, 1, 1); addVec(8'hF7, 1, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'h50, 0, 0, 0);

        // Five-octet packet: /R/ lands even, extra /R/; TX_EN during /R/ ignored.
        cur.txEn = 1'b1;
        cur.txd = 8'h55; addVec(8'hFB, 1, 1, 1);
        cur.txd = 8'h11; addVec(8'h11, 0, 0, 1);
        cur.txd = 8'h22; addVec(8'h22, 0, 1, 1);
        cur.txd = 8'h33; addVec(8'h33, 0, 0, 1);
        cur.txd = 8'h44; addVec(8'h44, 0, 1, 1);
        cur.txEn = 1'b0; addVec(8'hFD, 1, 0, 1);
        cur.txEn = 1'b1; addVec(8'hF7, 1, 1, 0); addVec(8'hF7, 1, 0, 0);
        cur.txEn = 1'b0; addVec(8'hBC, 1, 1, 0);

        // Odd-slot start, first octet dropped, TX_ER mid-packet -> /V/.
        cur.txEn = 1'b1; cur.rdn = 1'b0;
        cur.txd = 8'h55; addVec(8'hC5, 0, 0, 0);
        cur.txd = 8'hD5; addVec(8'hFB, 1, 1, 1);
        cur.txd = 8'hAA; addVec(8'hAA, 0, 0, 1);
        cur.txEr = 1'b1; cur.txd = 8'hBB; addVec(8'hFE, 1, 1, 1);
        cur.txEr = 1'b0; cur.txd = 8'hCC; addVec(8'hCC, 0, 0, 1);
        cur.txEn = 1'b0; addVec(8'hFD, 1, 1, 1); addVec(8'hF7, 1, 0, 0);
        cur.rdn = 1'b1; addVec(8'hBC, 1, 1, 0); addVec(8'h50, 0, 0, 0);

        // DATA -> CONFIG mid-packet forces /T/ /R/ then /C1/.
        cur.txEn = 1'b1;
        cur.txd = 8'h55; addVec(8'hFB, 1, 1, 1);
        cur.txd = 8'h66; addVec(8'h66, 0, 0, 1);
        cur.xmit = XC; cur.txd = 8'h77; addVec(8'hFD, 1, 1, 1);
        cur.txEn = 1'b0; addVec(8'hF7, 1, 0, 0);
        cur.cfg = 16'h1234; addVec(8'hBC, 1, 1, 0); addVec(8'hB5, 0, 0, 0);

        // Reset mid-/C1/, then CONFIG resumes from /C1/.
        cur.rst = 1'b1; addVec(8'hBC, 1, 1, 0);
        cur.rst = 1'b0; addVec(8'h50, 0, 0, 0);
        addVec(8'hBC, 1, 1, 0); addVec(8'hB5, 0, 0, 0);
        addVec(8'h34, 0, 1, 0); addVec(8'h12, 0, 0, 0);

        applyIn(vecs[0].in);
        for (int i = 0; i < vecs.size(); i++) begin
            applyIn(vecs[i].in);
            step();
            checkAll(i, vecs[i].code, vecs[i].isK, vecs[i].even, vecs[i].tx);
        end

        // Clock enable low for three cycles with busy inputs: outputs frozen.
        cke = 1'b0; xmit = XD; txEn = 1'b1; txd = 8'h99; rdn = 1'b0; cfg = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checkAll(1000 + i, 8'h12, 0, 0, 0);
        end
        // Resume: /C2/ continues at slot 4 and captures the word seen there.
        cke = 1'b1; xmit = XC; txEn = 1'b0; rdn = 1'b1; cfg = 16'h5678;
        step(); checkAll(1003, 8'hBC, 1, 1, 0);
        cfg = 16'h0000;
        step(); checkAll(1004, 8'h42, 0, 0, 0);
        step(); checkAll(1005, 8'h78, 0, 1, 0);
        step(); checkAll(1006, 8'h56, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
